mem_image_reader: RTL and testbench

//  Read-side neighbour of the memory block. It masters the memory's valid/ready port
//  and streams a contiguous address window out as WIDTH-bit words.

---
 rtl/mem_image_reader_if.sv | 33 +++
 rtl/mem_image_reader.sv | 177 +++++++++++++++++
 tb/tb_mem_image_reader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_image_reader_if.sv
// Bus bundle for mem_image_reader: the memory read port plus the output word stream.
// master: the reader side (drives requests and the stream); slave: memory model and sink.
interface mem_image_reader_if #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned ADDR_WIDTH = 6
);
   // memory port
   logic                  mem_wr_rd;
   logic                  mem_valid;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]      mem_wdata;
   logic [WIDTH-1:0]      mem_rdata;
   logic                  mem_ready;
   // output stream
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic                  out_last;
   logic                  out_ready;

   modport master (
      output mem_wr_rd, mem_valid, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output out_valid, out_data, out_last,
      input  out_ready
   );

   modport slave (
      input  mem_wr_rd, mem_valid, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  out_valid, out_data, out_last,
      output out_ready
   );
endinterface

// File: rtl/mem_image_reader.sv
// mem_image_reader: streams a contiguous (wrapping) memory window out through a small FIFO.
// One read outstanding at a time; requests are gated on FIFO space so a push never overflows.
// Optional feature: define MEM_READER_CHECKSUM_EN to add checksum/checksum_valid ports that
// report the wrapping sum of all words popped in the window, valid in the done cycle.
module mem_image_reader #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
`ifdef MEM_READER_CHECKSUM_EN
   output logic [WIDTH-1:0]      checksum,
   output logic                  checksum_valid,
`endif
   mem_image_reader_if.master    bus
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned LenW = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e                state_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  mem_valid_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [LenW-1:0]       remaining_q;

   logic [WIDTH-1:0]      fifo_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_last_q;
   logic [PtrW-1:0]       wr_ptr_q;
   logic [PtrW-1:0]       rd_ptr_q;
   logic [CntW-1:0]       count_q;

   logic                  push;
   logic                  pop;
   logic                  last_req;
   logic                  fifo_room;
   logic [CntW-1:0]       count_next;
   logic [LenW-1:0]       length_clamped;
   logic [ADDR_WIDTH-1:0] addr_inc;

   // Handshake decode, FIFO occupancy update, window clamp and wrapping address step
   always_comb begin
      push           = mem_valid_q && bus.mem_ready;
      pop            = (count_q != '0) && bus.out_ready;
      last_req       = (remaining_q == LenW'(1));
      fifo_room      = (count_q < CntW'(FIFO_DEPTH));
      count_next     = count_q;
      if (push && !pop) begin
         count_next = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_next = count_q - CntW'(1);
      end
      length_clamped = (length > LenW'(DEPTH)) ? LenW'(DEPTH) : length;
      addr_inc       = (mem_addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0
                                                              : mem_addr_q + ADDR_WIDTH'(1);
   end

   // Control FSM with registered busy/done and memory request outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         remaining_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  busy_q      <= 1'b1;
                  mem_addr_q  <= base_addr;
                  remaining_q <= length_clamped;
                  if (length_clamped == '0) begin
                     // Empty window: one busy cycle, then the done pulse via an empty drain
                     state_q <= StDrain;
                  end else begin
                     // FIFO is empty here, so the first request can go out immediately
                     state_q     <= StRead;
                     mem_valid_q <= 1'b1;
                  end
               end
            end
            StRead: begin
               if (push) begin
                  mem_valid_q <= 1'b0;
                  mem_addr_q  <= addr_inc;
                  remaining_q <= remaining_q - LenW'(1);
                  if (last_req) begin
                     state_q <= StDrain;
                  end
               end else if (!mem_valid_q && fifo_room) begin
                  // Room is counted before this edge's pop, so the later push always fits
                  mem_valid_q <= 1'b1;
               end
            end
            StDrain: begin
               if (count_next == '0) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Output FIFO storage and pointers; entries are cleared on reset so the head reads 0
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         fifo_last_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
         end
      end else begin
         if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.mem_rdata;
            fifo_last_q[wr_ptr_q] <= last_req;
            wr_ptr_q              <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         count_q <= count_next;
      end
   end

`ifdef MEM_READER_CHECKSUM_EN
   logic [WIDTH-1:0] checksum_q;

   // Running sum of popped words, cleared when a window is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= '0;
      end else if (state_q == StIdle && start) begin
         checksum_q <= '0;
      end else if (pop) begin
         checksum_q <= checksum_q + bus.out_data;
      end
   end

   assign checksum       = checksum_q;
   assign checksum_valid = done_q;
`endif

   assign busy          = busy_q;
   assign done          = done_q;
   assign bus.mem_wr_rd = 1'b0;
   assign bus.mem_wdata = '0;
   assign bus.mem_valid = mem_valid_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = fifo_data_q[rd_ptr_q];
   assign bus.out_last  = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_image_reader.sv
// Self-checking bench for mem_image_reader: table-driven windows, hand-written corner
// sequences and randomized windows compared against a simple window model.
module tb_mem_image_reader;
   localparam int W  = 16;
   localparam int D  = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy;
   logic          done;
`ifdef MEM_READER_CHECKSUM_EN
   logic [W-1:0]  checksum;
   logic          checksum_valid;
`endif

   mem_image_reader_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus ();

   logic [W-1:0] mem_model [D];
   assign bus.mem_rdata = mem_model[bus.mem_addr];

   int mem_pct = 100;
   int out_pct = 100;

   always #5 clk = ~clk;

   mem_image_reader #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
`ifdef MEM_READER_CHECKSUM_EN
      .checksum       (checksum),
      .checksum_valid (checksum_valid),
`endif
      .bus       (bus)
   );

   // Ready drivers: probability in percent, 0 = never, 100 = always
   initial begin
      bus.mem_ready = 1'b0;
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_ready = (int'($urandom_range(99)) < mem_pct);
         bus.out_ready = (int'($urandom_range(99)) < out_pct);
      end
   end

   // Monitor (negedge): record transfers, done pulses and hold-stability violations
   int cyc = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0;
   int stab_err = 0, mv_cycles = 0, const_err = 0;
   int pop_q[$];
   int plast_q[$];
   int addr_q[$];
   int cs_at_done = 0;
   logic          pmv = 0, pmr = 0, pov = 0, por = 0, plast = 0;
   logic [AW-1:0] pma = '0;
   logic [W-1:0]  pod = '0;

   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (bus.mem_valid && bus.mem_ready) addr_q.push_back(int'(bus.mem_addr));
         if (bus.out_valid && bus.out_ready) begin
            pop_q.push_back(int'(bus.out_data));
            plast_q.push_back(int'(bus.out_last));
            last_pop_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef MEM_READER_CHECKSUM_EN
            if (checksum_valid) cs_at_done = int'(checksum);
`endif
         end
         if (bus.mem_valid) mv_cycles++;
         if (pmv && !pmr && (!bus.mem_valid || bus.mem_addr != pma)) stab_err++;
         if (pov && !por && (!bus.out_valid || bus.out_data != pod || bus.out_last != plast))
            stab_err++;
         if (bus.mem_wr_rd !== 1'b0 || bus.mem_wdata !== '0) const_err++;
      end
      pmv = bus.mem_valid; pmr = bus.mem_ready; pma = bus.mem_addr;
      pov = bus.out_valid; por = bus.out_ready; pod = bus.out_data; plast = bus.out_last;
   end

   int total_cnt = 0;
   int pass_cnt  = 0;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic clear_mon();
      pop_q.delete();
      plast_q.delete();
      addr_q.delete();
      done_cnt = 0;
      stab_err = 0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge clk);
      if (done_cnt == 0) check("done_timeout", 0, 1);
   endtask

   task automatic pulse_start(input int base, input int len);
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = AW'(base);
      length    = (AW + 1)'(len);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Model: window of min(len, D) words from consecutive addresses modulo D, last on final
   task automatic compare_window(input string tag, input int base, input int len);
      int n, errs;
      n    = (len > D) ? D : len;
      errs = 0;
      check({tag, ":words"}, pop_q.size(), n);
      check({tag, ":reads"}, addr_q.size(), n);
      for (int i = 0; i < n; i++) begin
         int a;
         a = (base + i) % D;
         if (i < addr_q.size() && addr_q[i] != a) errs++;
         if (i < pop_q.size()) begin
            if (pop_q[i] != int'(mem_model[a])) errs++;
            if (plast_q[i] != ((i == n - 1) ? 1 : 0)) errs++;
         end
      end
      check({tag, ":seq_errs"}, errs, 0);
      check({tag, ":done_once"}, done_cnt, 1);
      if (n > 0) check({tag, ":done_timing"}, done_cyc, last_pop_cyc + 1);
      check({tag, ":hold_stable"}, stab_err, 0);
   endtask

   task automatic run_window(input string tag, input int base, input int len,
                             input int mp, input int op);
      mem_pct = mp;
      out_pct = op;
      clear_mon();
      pulse_start(base, len);
      wait_done(4000);
      repeat (3) @(posedge clk);
      compare_window(tag, base, len);
   endtask

   typedef struct {
      int    base;
      int    len;
      int    mp;
      int    op;
      int    exp_n;
      int    exp_first;
      int    exp_last;
      string name;
   } vec_t;

   initial begin
      vec_t tbl[5];
      int   mv0;
      tbl[0] = '{0,  64,  100, 100, 64, 'h1000, 'h103F, "full"};
      tbl[1] = '{62, 4,   100, 100, 4,  'h103E, 'h1001, "wrap"};
      tbl[2] = '{5,  100, 100, 100, 64, 'h1005, 'h1004, "clamp"};
      tbl[3] = '{40, 16,  50,  60,  16, 'h1028, 'h1037, "jitter"};
      tbl[4] = '{33, 1,   100, 100, 1,  'h1021, 'h1021, "single"};

      for (int i = 0; i < D; i++) mem_model[i] = W'(16'h1000 + i);

      // Reset and idle
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst:busy", int'(busy), 0);
      check("rst:done", int'(done), 0);
      check("rst:outs", int'({bus.mem_valid, bus.mem_addr, bus.out_valid, bus.out_last}), 0);
      check("rst:out_data", int'(bus.out_data), 0);
      mv0 = mv_cycles;
      repeat (10) @(posedge clk);
      check("idle:no_mem_valid", mv_cycles - mv0, 0);

      // Table of windows
      foreach (tbl[k]) begin
         run_window(tbl[k].name, tbl[k].base, tbl[k].len, tbl[k].mp, tbl[k].op);
         check({tbl[k].name, ":n"}, pop_q.size(), tbl[k].exp_n);
         if (pop_q.size() > 0) begin
            check({tbl[k].name, ":first"}, pop_q[0], tbl[k].exp_first);
            check({tbl[k].name, ":last"}, pop_q[pop_q.size() - 1], tbl[k].exp_last);
         end
      end

      // Latency: start -> mem_valid 1 cycle, accepted read -> out_valid 1 cycle
      mem_pct = 100; out_pct = 100;
      clear_mon();
      pulse_start(7, 2);
      @(negedge clk);
      check("lat:busy", int'(busy), 1);
      check("lat:mem_valid", int'(bus.mem_valid), 1);
      check("lat:mem_addr", int'(bus.mem_addr), 7);
      check("lat:out_valid_early", int'(bus.out_valid), 0);
      @(negedge clk);
      check("lat:out_valid", int'(bus.out_valid), 1);
      check("lat:out_data", int'(bus.out_data), 'h1007);
      check("lat:req_gap", int'(bus.mem_valid), 0);
      wait_done(200);
      repeat (3) @(posedge clk);
      compare_window("lat", 7, 2);

      // Backpressure: exactly FIFO_DEPTH reads while out_ready is low
      mem_pct = 100; out_pct = 0;
      clear_mon();
      pulse_start(0, 8);
      repeat (30) @(posedge clk);
      check("bp:reads_held", addr_q.size(), 4);
      check("bp:mem_valid_low", int'(bus.mem_valid), 0);
      check("bp:no_pops", pop_q.size(), 0);
      out_pct = 100;
      wait_done(200);
      repeat (3) @(posedge clk);
      compare_window("bp", 0, 8);

      // Stall: mem_ready low, request must hold
      mem_pct = 0; out_pct = 100;
      clear_mon();
      pulse_start(20, 3);
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("stall:valid_held", int'(bus.mem_valid), 1);
      check("stall:addr_held", int'(bus.mem_addr), 20);
      check("stall:stable", stab_err, 0);
      mem_pct = 100;
      wait_done(200);
      repeat (3) @(posedge clk);
      compare_window("stall", 20, 3);

      // Zero length: busy one cycle, done the next, no memory access
      clear_mon();
      mv0 = mv_cycles;
      pulse_start(9, 0);
      @(negedge clk);
      check("len0:busy", int'({busy, done}), 2);
      @(negedge clk);
      check("len0:done", int'({busy, done}), 1);
      @(negedge clk);
      check("len0:done_pulse", int'(done), 0);
      check("len0:no_mem", mv_cycles - mv0, 0);

`ifdef MEM_READER_CHECKSUM_EN
      run_window("cs", 0, 4, 100, 100);
      check("cs:sum", cs_at_done, 'h4006);
`endif

      // Randomized windows with random memory contents
      for (int i = 0; i < D; i++) mem_model[i] = W'($urandom);
      for (int r = 0; r < 12; r++) begin
         run_window("rand", int'($urandom_range(D - 1)), int'($urandom_range(70)),
                    int'($urandom_range(100, 30)), int'($urandom_range(100, 30)));
      end

      // Reset at word 3 of 10, then a fresh window
      for (int i = 0; i < D; i++) mem_model[i] = W'(16'h1000 + i);
      mem_pct = 100; out_pct = 100;
      clear_mon();
      pulse_start(0, 10);
      for (int i = 0; i < 100 && pop_q.size() < 3; i++) @(posedge clk);
      check("abort:reached", int'(pop_q.size() >= 3), 1);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort:busy", int'({busy, done}), 0);
      check("abort:outs", int'({bus.mem_valid, bus.mem_addr, bus.out_valid, bus.out_last}), 0);
      check("abort:out_data", int'(bus.out_data), 0);
      repeat (8) @(posedge clk);
      check("abort:no_done", done_cnt, 0);
      run_window("after_abort", 0, 2, 100, 100);
      check("const:wr_rd_wdata", const_err, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
